// File: rtl/cp0_unit.sv
// Coprocessor-0 at the M stage: SR/Cause/EPC, interrupt/exception request, mfc0/mtc0, eret.
// Optional read-only PRId register at addr 15 when CP0_PRID_EN is defined.
module cp0_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
`ifdef CP0_PRID_EN
    ,
    parameter logic [31:0] PRID_VALUE = 32'h2022_0007
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
`ifdef CP0_PRID_EN
    localparam logic [4:0] ADDR_PRID  = 5'd15;
`endif

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:2] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] epc_word;

    // Word alignment drops the low PC bits; (vpc - 4)[31:2] equals vpc[31:2] - 1.
    logic [1:0]  unused_vpc_low;
    assign unused_vpc_low = vpc[1:0];

    assign int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
    assign exc_req = (exc_code_in != 5'd0) & ~exl_q;
    assign req     = int_req | exc_req;

    assign sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_word = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'b00};
    assign epc_word   = {epc_q, 2'b00};

    assign epc_out    = epc_word;
    assign handler_pc = HANDLER_ADDR;

    always_comb begin
        dout = 32'd0;
        case (addr)
            ADDR_SR:    dout = sr_word;
            ADDR_CAUSE: dout = cause_word;
            ADDR_EPC:   dout = epc_word;
`ifdef CP0_PRID_EN
            ADDR_PRID:  dout = PRID_VALUE;
`endif
            default:    dout = 32'd0;
        endcase
    end

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = hw_int;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (req) begin
            // Taking an exception overrides any mtc0 or eret in the same cycle.
            exl_d      = 1'b1;
            bd_d       = bd_in;
            exc_code_d = int_req ? 5'd0 : exc_code_in;
            epc_d      = bd_in ? (vpc[31:2] - 30'd1) : vpc[31:2];
        end else begin
            if (we && addr == ADDR_SR) begin
                im_d  = din[15:10];
                exl_d = din[1];
                ie_d  = din[0];
            end
            if (we && addr == ADDR_EPC) begin
                epc_d = din[31:2];
            end
            if (eret) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 30'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: word-level model of SR/Cause/EPC checked every cycle,
// plus directed literal checks and a randomized phase.
module tb_cp0_unit;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    int n_cmp;
    int n_bad;
    bit chk_en;

    // Architectural register images as software sees them.
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    cp0_unit dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .addr        (addr),
        .din         (din),
        .dout        (dout),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .eret        (eret),
        .req         (req),
        .epc_out     (epc_out),
        .handler_pc  (handler_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_int_req();
        return ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic bit m_req();
        return m_int_req() || ((exc_code_in != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_dout(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
`ifdef CP0_PRID_EN
            5'd15:   return 32'h2022_0007;
`endif
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [31:0] victim;
        if (reset) begin
            m_sr    = 32'd0;
            m_cause = 32'd0;
            m_epc   = 32'd0;
        end else begin
            logic take;
            logic take_int;
            take     = m_req();
            take_int = m_int_req();
            m_cause  = (m_cause & ~32'h0000_FC00) | (32'(hw_int) << 10);
            if (take) begin
                m_sr    = m_sr | 32'h2;
                victim  = bd_in ? vpc - 32'd4 : vpc;
                m_epc   = victim & ~32'h3;
                m_cause = (m_cause & 32'h0000_FC00) | (bd_in ? 32'h8000_0000 : 32'd0)
                          | (take_int ? 32'd0 : (32'(exc_code_in) << 2));
            end else begin
                if (we && addr == 5'd12) m_sr = din & 32'h0000_FC03;
                if (we && addr == 5'd14) m_epc = din & ~32'h3;
                if (eret) m_sr = m_sr & ~32'h2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (req !== m_req() || dout !== m_dout(addr) || epc_out !== m_epc
                || handler_pc !== 32'h0000_4180) begin
                n_bad++;
                $display("FAIL cycle_model t=%0t addr=%0d: req=%b/%b dout=%h/%h epc_out=%h/%h hpc=%h/%h",
                         $time, addr, req, m_req(), dout, m_dout(addr), epc_out, m_epc,
                         handler_pc, 32'h0000_4180);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, dout, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; addr = 5'd0; din = 0; vpc = 0; bd_in = 0;
        exc_code_in = 0; hw_int = 0; eret = 0; reset = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        chk_en = 0;
        idle();
        reset = 1;
        hw_int = 6'h3F;
        tick();
        tick();
        reset = 0;
        chk_en = 1;
        rd("reset_sr", 5'd12, 32'h0);
        rd("reset_cause", 5'd13, 32'h0);
        rd("reset_epc", 5'd14, 32'h0);
        check("reset_req", {31'd0, req}, 32'd0);
        hw_int = 0;

        // Enable IM[10]+IE, then take interrupt 0.
        we = 1; addr = 5'd12; din = 32'h0000_0401;
        tick();
        we = 0; hw_int = 6'h01; vpc = 32'h0000_3010; bd_in = 0;
        #1 check("int_req", {31'd0, req}, 32'd1);
        tick();
        rd("int_sr", 5'd12, 32'h0000_0403);
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_epc", 5'd14, 32'h0000_3010);
        check("int_req_after", {31'd0, req}, 32'd0);

        // Exception in a delay slot.
        hw_int = 0; eret = 1;
        tick();
        eret = 0; exc_code_in = 5'd4; vpc = 32'h0000_3024; bd_in = 1;
        #1 check("exc_req", {31'd0, req}, 32'd1);
        tick();
        exc_code_in = 0; bd_in = 0;
        rd("exc_cause", 5'd13, 32'h8000_0010);
        rd("exc_epc", 5'd14, 32'h0000_3020);

        // Interrupt wins over simultaneous exception; nothing taken under EXL.
        eret = 1;
        tick();
        eret = 0; hw_int = 6'h01; exc_code_in = 5'd10; vpc = 32'h0000_3100;
        tick();
        hw_int = 0; exc_code_in = 0;
        rd("prio_cause", 5'd13, 32'h0000_0400);
        exc_code_in = 5'd12;
        #1 check("exl_block_req", {31'd0, req}, 32'd0);
        tick();
        exc_code_in = 0;
        rd("exl_block_cause", 5'd13, 32'h0000_0000);
        rd("exl_block_epc", 5'd14, 32'h0000_3100);
        rd("exl_block_sr", 5'd12, 32'h0000_0403);

        // EPC write alignment, eret, then re-trigger with a discarded mtc0.
        we = 1; addr = 5'd14; din = 32'h0000_3047;
        tick();
        we = 0;
        rd("mtc0_epc", 5'd14, 32'h0000_3044);
        check("mtc0_epc_out", epc_out, 32'h0000_3044);
        hw_int = 6'h01; eret = 1;
        #1 check("eret_cycle_req", {31'd0, req}, 32'd0);
        tick();
        eret = 0;
        rd("eret_sr", 5'd12, 32'h0000_0401);
        we = 1; addr = 5'd12; din = 32'h0;
        #1 check("reraise_req", {31'd0, req}, 32'd1);
        tick();
        we = 0; hw_int = 0;
        rd("discard_sr", 5'd12, 32'h0000_0403);
`ifdef CP0_PRID_EN
        rd("prid", 5'd15, 32'h2022_0007);
`else
        rd("prid", 5'd15, 32'h0);
`endif

        // Randomized phase: the per-cycle model comparison does the checking.
        for (int i = 0; i < 4000; i++) begin
            int sel;
            reset = ($urandom_range(0, 199) == 0);
            we = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 4);
            addr = (sel == 0) ? 5'd12 : (sel == 1) ? 5'd13 : (sel == 2) ? 5'd14 :
                   (sel == 3) ? 5'd15 : 5'($urandom_range(0, 31));
            din = $urandom;
            vpc = $urandom;
            bd_in = 1'($urandom_range(0, 1));
            exc_code_in = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            hw_int = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            eret = ($urandom_range(0, 5) == 0);
            tick();
        end
        idle();
        tick();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
